dmem_responder: RTL and testbench

Data-memory responder on the far end of the CPU's shared 64-bit bidirectional mem_data bus. The CPU is the initiator and drives the bus on stores. This block captures stores into a word array and drives the bus with load data. After the CPU signals halt, it scans the whole array out on a dump port so the testbench can check results. It sits beside the pipelined core in the top-level system, one per core.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder and system benches.
// Holds the FSM encoding, bus width and the core's NOP encoding.
package dmem_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_IDLE    = 3'd1,
    S_RD_RESP = 3'd2,
    S_WR_RESP = 3'd3,
    S_DUMP    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [31:0] NOP_INSN = {
    12'd0, 5'd0, 3'b000, 5'd0, OPC_OP_IMM
  };

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake between the CPU and the data-memory responder.
// The 64-bit data bus itself is a separate inout on the responder.
interface dmem_responder_if;

  logic        mem_req;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_rw,
    output mem_addr,
    input  mem_ready,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_rw,
    input  mem_addr,
    output mem_ready,
    output mem_ack
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read.
// No reset; contents are zeroed by the responder's clear sweep.
module dmem_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: clears, serves loads/stores on the shared bus,
// then scans the whole array out on the dump port after halt.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              misalign,
  output logic              bus_conflict,
  input  logic              halt,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] rd_q;
  logic              ready_q;
  logic              ack_q;

  logic              we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic              oe;
  logic              unused_addr;

  assign idx = bus.mem_addr[ADDR_W+2:3];
  assign unused_addr = ^bus.mem_addr[31:ADDR_W+3];
  assign accept = (state == S_IDLE) & !halt & bus.mem_req;

  // One array port shared by the clear sweep, accesses and the dump.
  always_comb begin
    we = 1'b0;
    arr_addr = idx;
    arr_wdata = mem_data;
    unique case (1'b1)
      state == S_CLEAR: begin
        we = 1'b1;
        arr_addr = cnt[ADDR_W-1:0];
        arr_wdata = '0;
      end
      state == S_DUMP: begin
        arr_addr = cnt[ADDR_W-1:0];
      end
      default: begin
        we = accept & bus.mem_rw;
      end
    endcase
  end

  dmem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  // A store collision in the response cycle must never see us driving.
  assign oe = (state == S_RD_RESP) & !bus.mem_rw;
  assign mem_data = oe ? rd_q : 'z;

  assign bus.mem_ready = ready_q;
  assign bus.mem_ack = ack_q;
  assign dump_addr = dump_valid ? cnt[ADDR_W-1:0] : '0;
  assign dump_data = dump_valid ? arr_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt <= '0;
      rd_q <= '0;
      ready_q <= 1'b0;
      ack_q <= 1'b0;
      misalign <= 1'b0;
      bus_conflict <= 1'b0;
      dump_valid <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt <= '0;
            state <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (halt) begin
            state <= S_DUMP;
            ready_q <= 1'b0;
            dump_valid <= 1'b1;
          end else if (bus.mem_req) begin
            ready_q <= 1'b0;
            ack_q <= 1'b1;
            if (bus.mem_addr[2:0] != 3'd0) misalign <= 1'b1;
            if (bus.mem_rw) begin
              state <= S_WR_RESP;
            end else begin
              state <= S_RD_RESP;
              rd_q <= arr_rdata;
            end
          end
        end
        S_RD_RESP, S_WR_RESP: begin
          ack_q <= 1'b0;
          if (state == S_RD_RESP && bus.mem_rw) bus_conflict <= 1'b1;
          if (halt) begin
            state <= S_DUMP;
            dump_valid <= 1'b1;
          end else begin
            state <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_DUMP: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt <= '0;
            state <= S_DONE;
            dump_valid <= 1'b0;
            dump_done <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, hand sequences and random
// traffic checked against a word-array model of the memory.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int AW = 10;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  wire  [63:0] mem_data;
  logic        tb_oe = 1'b0;
  logic [63:0] tb_drv = '0;
  assign mem_data = tb_oe ? tb_drv : 'z;

  logic          misalign;
  logic          bus_conflict;
  logic          dump_valid;
  logic [AW-1:0] dump_addr;
  logic [63:0]   dump_data;
  logic          dump_done;

  dmem_responder #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mem_data    (mem_data),
    .misalign    (misalign),
    .bus_conflict(bus_conflict),
    .halt        (halt),
    .dump_valid  (dump_valid),
    .dump_addr   (dump_addr),
    .dump_data   (dump_data),
    .dump_done   (dump_done)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] mdl [DEPTH];

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [63:0] data;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(logic [31:0] a);
    return int'((a >> 3) % DEPTH);
  endfunction

  task automatic mdl_clear();
    foreach (mdl[i]) mdl[i] = '0;
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.mem_ready, bus.mem_ack, misalign, bus_conflict,
                dump_valid, dump_done, dump_addr}) | dump_data;
  endfunction

  task automatic wait_clear();
    int n = 0;
    while (!bus.mem_ready && n < 2000) begin
      tick();
      n++;
    end
    chk("clear_len", 64'(n), 64'd1024);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.mem_ready && n < 8) begin
      tick();
      n++;
    end
    chk("ready_wait", 64'(bus.mem_ready), 64'd1);
  endtask

  task automatic store(logic [31:0] a, logic [63:0] d);
    wait_ready();
    bus.mem_req = 1'b1;
    bus.mem_rw = 1'b1;
    bus.mem_addr = a;
    tb_oe = 1'b1;
    tb_drv = d;
    tick();
    mdl[widx(a)] = d;
    chk("wr_ack", 64'(bus.mem_ack), 64'd1);
    chk("wr_ready", 64'(bus.mem_ready), 64'd0);
    bus.mem_req = 1'b0;
    tb_oe = 1'b0;
    tick();
    chk("wr_ack_end", 64'(bus.mem_ack), 64'd0);
  endtask

  task automatic load(logic [31:0] a, logic [63:0] exp);
    wait_ready();
    bus.mem_req = 1'b1;
    bus.mem_rw = 1'b0;
    bus.mem_addr = a;
    tick();
    chk("rd_ack", 64'(bus.mem_ack), 64'd1);
    chk("rd_data", mem_data, exp);
    bus.mem_req = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int beats;
    logic [31:0] a;
    logic [63:0] d;
    bus.mem_req = 1'b0;
    bus.mem_rw = 1'b0;
    bus.mem_addr = '0;
    mdl_clear();

    #3;
    chk("reset_outs", outs(), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_clear();

    tbl[0] = '{1'b0, 32'h0000_0040, 64'h0};
    tbl[1] = '{1'b1, 32'h0000_0018, 64'hDEADBEEF_01234567};
    tbl[2] = '{1'b0, 32'h0000_0018, 64'hDEADBEEF_01234567};
    tbl[3] = '{1'b1, 32'h0000_1FF8, 64'h0123_4567_89AB_CDEF};
    tbl[4] = '{1'b0, 32'h0000_1FF8, 64'h0123_4567_89AB_CDEF};
    tbl[5] = '{1'b1, 32'h0000_2000, 64'hFFFF_0000_FFFF_0000};
    tbl[6] = '{1'b0, 32'h0000_0000, 64'hFFFF_0000_FFFF_0000};
    tbl[7] = '{1'b0, 32'h0000_1FF8, 64'h0123_4567_89AB_CDEF};
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rw) store(tbl[i].addr, tbl[i].data);
      else load(tbl[i].addr, tbl[i].data);
    end
    chk("misalign_clean", 64'(misalign), 64'd0);

    store(32'h1D, 64'hA5A5_0000_1111_2222);
    chk("misalign_set", 64'(misalign), 64'd1);
    load(32'h18, 64'hA5A5_0000_1111_2222);

    // Request held across WR_RESP is only taken in the next IDLE cycle.
    bus.mem_req = 1'b1;
    bus.mem_rw = 1'b1;
    bus.mem_addr = 32'h30;
    tb_oe = 1'b1;
    tb_drv = 64'h3030_3030_3030_3030;
    tick();
    chk("hold_ack1", 64'(bus.mem_ack), 64'd1);
    bus.mem_addr = 32'h38;
    tb_drv = 64'h3838_3838_3838_3838;
    tick();
    chk("hold_idle_ack", 64'(bus.mem_ack), 64'd0);
    chk("hold_idle_rdy", 64'(bus.mem_ready), 64'd1);
    tick();
    chk("hold_ack2", 64'(bus.mem_ack), 64'd1);
    bus.mem_req = 1'b0;
    tb_oe = 1'b0;
    tick();
    mdl[6] = 64'h3030_3030_3030_3030;
    mdl[7] = 64'h3838_3838_3838_3838;
    load(32'h30, mdl[6]);
    load(32'h38, mdl[7]);

    bus.mem_req = 1'b1;
    bus.mem_rw = 1'b0;
    bus.mem_addr = 32'h18;
    tick();
    bus.mem_req = 1'b0;
    bus.mem_rw = 1'b1;
    tb_oe = 1'b1;
    tb_drv = 64'h5A5A_5A5A_C3C3_C3C3;
    #1;
    chk("conflict_bus", mem_data, 64'h5A5A_5A5A_C3C3_C3C3);
    chk("conflict_ack", 64'(bus.mem_ack), 64'd1);
    tick();
    chk("conflict_flag", 64'(bus_conflict), 64'd1);
    bus.mem_rw = 1'b0;
    tb_oe = 1'b0;
    load(32'h18, mdl[3]);

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      d = {$urandom, $urandom};
      if ($urandom_range(1, 0) == 1) store(a, d);
      else load(a, mdl[widx(a)]);
    end

    wait_ready();
    bus.mem_req = 1'b1;
    bus.mem_rw = 1'b0;
    bus.mem_addr = 32'h18;
    tick();
    halt = 1'b1;
    bus.mem_req = 1'b0;
    #1;
    chk("halt_rd_data", mem_data, mdl[3]);
    chk("halt_rd_ack", 64'(bus.mem_ack), 64'd1);
    tick();
    beats = 0;
    while (dump_valid && beats < DEPTH + 4) begin
      chk("dump_addr", 64'(dump_addr), 64'(beats));
      chk("dump_data", dump_data, mdl[beats]);
      beats++;
      tick();
    end
    chk("dump_beats", 64'(beats), 64'd1024);
    chk("dump_done", 64'(dump_done), 64'd1);
    halt = 1'b0;
    repeat (5) tick();
    chk("done_sticky", 64'(dump_done), 64'd1);
    chk("done_ready", 64'(bus.mem_ready), 64'd0);

    rst = 1'b1;
    #1;
    chk("rst_from_done", outs(), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    mdl_clear();
    wait_clear();
    store(32'h18, 64'h1234_5678_9ABC_DEF0);

    // halt wins over a same-cycle store, which is dropped.
    bus.mem_req = 1'b1;
    bus.mem_rw = 1'b1;
    bus.mem_addr = 32'h18;
    tb_oe = 1'b1;
    tb_drv = 64'hBAD0_BAD0_BAD0_BAD0;
    halt = 1'b1;
    tick();
    chk("halt_prio_ack", 64'(bus.mem_ack), 64'd0);
    chk("halt_prio_dv", 64'(dump_valid), 64'd1);
    bus.mem_req = 1'b0;
    tb_oe = 1'b0;
    beats = 0;
    while (dump_valid && beats < 500) begin
      chk("dump2_data", dump_data, mdl[beats]);
      beats++;
      tick();
    end
    chk("dump2_beats", 64'(beats), 64'd500);
    chk("dump2_addr", 64'(dump_addr), 64'd500);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_dump", outs(), 64'd0);
    halt = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    mdl_clear();
    wait_clear();
    load(32'h18, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
